// File: rtl/apb_cmd_master.sv
// APB requester fed by a valid/ready command stream; commands are queued in a FIFO,
// issued strictly in order, and each produces exactly one response (data, error, timeout).
module apb_cmd_master #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_strb,
  input  logic [2:0]            req_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  output logic [2:0]            pprot,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_W-1:0]     prdata
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [2:0]        prot;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  cmd_t               mem [FIFO_DEPTH];
  cmd_t               head_c;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_c, pop_c, clr_bus_c;

  state_t             state_q, state_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;

  logic               psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0]  paddr_d;
  logic [DATA_W-1:0]  pwdata_d;
  logic [STRB_W-1:0]  pstrb_d;
  logic [2:0]         pprot_d;
  logic               rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_W-1:0]  rsp_rdata_d;

  assign push_c = req_valid & req_ready;
  assign head_c = mem[rd_ptr_q];

  // FIFO storage needs no reset; pointers and level are reset below
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= '{write: req_write, addr: req_addr, wdata: req_wdata,
                                   strb: req_strb, prot: req_prot};
  end

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      req_ready <= (count_d != CNT_W'(FIFO_DEPTH));
      busy      <= (count_d != '0) || (state_d != S_IDLE);
    end
  end

  // Next state and next registered bus/response values
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pop_c         = 1'b0;
    clr_bus_c     = 1'b0;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    pstrb_d       = pstrb;
    pprot_d       = pprot;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          clr_bus_c     = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite ? '0 : prdata;
          state_d       = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_W'(TO_LAST)) begin
          clr_bus_c     = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = S_RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          if (count_q != '0) begin
            pop_c   = 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus fields read as zero whenever psel is low
    if (clr_bus_c) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
      pstrb_d   = '0;
      pprot_d   = '0;
    end

    if (pop_c) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = head_c.write;
      paddr_d   = head_c.addr;
      pwdata_d  = head_c.write ? head_c.wdata : '0;
      pstrb_d   = head_c.write ? head_c.strb  : '0;
      pprot_d   = head_c.prot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      pstrb       <= pstrb_d;
      pprot       <= pprot_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: completer model driven by a per-command plan, response
// scoreboard fed at command acceptance, and a monitor that checks bus and responses.
module tb_apb_cmd_master;

  localparam int unsigned TO = 8;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    bit          slverr;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_rsp   = 0;
  int    rsp_mode = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference: the response a command must produce given how the completer will behave
  function automatic exp_t model(plan_t p);
    exp_t e;
    e.tout  = (p.waits >= int'(TO));
    e.err   = e.tout || p.slverr;
    e.rdata = (p.write || e.tout) ? 32'h0 : p.rdata;
    return e;
  endfunction

  function automatic plan_t rand_plan(int max_waits);
    plan_t p;
    p.write  = 1'($urandom_range(0, 1));
    p.addr   = $urandom;
    p.wdata  = $urandom;
    p.strb   = 4'($urandom_range(0, 15));
    p.prot   = 3'($urandom_range(0, 7));
    p.waits  = $urandom_range(0, max_waits);
    p.slverr = ($urandom_range(0, 4) == 0);
    p.rdata  = $urandom;
    return p;
  endfunction

  function automatic plan_t mk(bit w, logic [31:0] a, logic [31:0] d, int waits, bit err,
                               logic [31:0] rd);
    plan_t p;
    p.write = w; p.addr = a; p.wdata = d; p.strb = 4'hF; p.prot = 3'd0;
    p.waits = waits; p.slverr = err; p.rdata = rd;
    return p;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic push_cmd(input plan_t p);
    int guard = 0;
    req_valid = 1'b1; req_write = p.write; req_addr = p.addr;
    req_wdata = p.wdata; req_strb = p.strb; req_prot = p.prot;
    while (!req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("push_budget", 128'(0), 128'(1));
    end else begin
      plan_q.push_back(p);
      exp_q.push_back(model(p));
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(string name, int budget);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 128'(exp_q.size() != 0 || busy), 128'(0));
  endtask

  // Completer: follows the plan of the command currently on the bus
  initial begin
    plan_t cur;
    bit    active = 1'b0;
    int    wcnt = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge clk);
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      if (rst) begin
        active = 1'b0;
        continue;
      end
      if (!psel) begin
        active = 1'b0;
        check("bus_idle_zero", {penable, pwrite, paddr, pwdata, pstrb, pprot}, '0);
      end else begin
        if (!penable) begin
          if (plan_q.size() == 0) begin
            check("unexpected_transfer", 128'(1), 128'(0));
            active = 1'b0;
          end else begin
            cur = plan_q.pop_front();
            active = 1'b1;
            wcnt = 0;
          end
        end
        if (active) begin
          check("bus_fields", {pwrite, paddr, pwdata, pstrb, pprot},
                {cur.write, cur.addr, cur.write ? cur.wdata : 32'h0,
                 cur.write ? cur.strb : 4'h0, cur.prot});
          if (penable) begin
            if (wcnt == cur.waits) begin
              pready = 1'b1;
              pslverr = cur.slverr;
              if (!cur.write) prdata = cur.rdata;
            end else begin
              wcnt++;
            end
          end
        end
      end
    end
  end

  // Response monitor: scoreboard pop on handshake, hold check while stalled
  initial begin
    exp_t e;
    bit          held = 1'b0;
    logic [33:0] held_v = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_ready = 1'b0;
        held = 1'b0;
        continue;
      end
      case (rsp_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      if (rsp_valid) begin
        if (held) check("rsp_hold", {rsp_rdata, rsp_err, rsp_timeout}, held_v);
        if (rsp_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 128'(1), 128'(0));
          end else begin
            e = exp_q.pop_front();
            n_rsp++;
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
            check("rsp_timeout", rsp_timeout, e.tout);
          end
        end else begin
          held = 1'b1;
          held_v = {rsp_rdata, rsp_err, rsp_timeout};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, base, guard;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready, rsp_valid, psel, penable, busy, paddr, rsp_rdata}, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", 128'(req_ready), 128'(1));
    check("idle_outputs", {rsp_valid, rsp_err, rsp_timeout, busy, psel, penable, pwrite,
                           paddr, pwdata, pstrb, pprot, rsp_rdata}, '0);

    // Zero-wait write latency
    rsp_mode = 1;
    push_cmd(mk(1'b1, 32'h10, 32'hCAFE_F00D, 0, 1'b0, 32'h0));
    check("lat_n", {psel, penable}, 128'(2'b00));
    @(negedge clk);
    check("lat_setup", {psel, penable}, 128'(2'b10));
    @(negedge clk);
    check("lat_access", {psel, penable}, 128'(2'b11));
    @(negedge clk);
    check("lat_rsp", {rsp_valid, rsp_err, psel}, 128'(3'b100));
    drain("drain_write", 100);

    // Read with 3 wait states
    push_cmd(mk(1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h1234_5678));
    cnt = 0; guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      if (penable) cnt++;
      guard++;
    end
    check("read_penable_cycles", 128'(cnt), 128'(4));
    check("read_rdata", rsp_rdata, 128'(32'h1234_5678));
    drain("drain_read", 100);

    // Fill the FIFO behind a stalled response
    rsp_mode = 0;
    base = n_rsp;
    for (int i = 0; i < 5; i++) push_cmd(rand_plan(2));
    repeat (4) @(negedge clk);
    check("fifo_full_ready", 128'(req_ready), 128'(0));
    check("fifo_full_busy", 128'(busy), 128'(1));
    rsp_mode = 1;
    drain("drain_five", 200);
    check("five_rsp_count", 128'(n_rsp - base), 128'(5));

    // Timeout followed by a normal command
    push_cmd(mk(1'b0, 32'h40, 32'h0, 30, 1'b0, 32'hDEAD_BEEF));
    push_cmd(mk(1'b1, 32'h44, 32'h5555_AAAA, 1, 1'b0, 32'h0));
    cnt = 0; guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      if (penable) cnt++;
      guard++;
    end
    check("timeout_access_cycles", 128'(cnt), 128'(TO));
    drain("drain_timeout", 100);

    // Slave error, then reset during the next transfer's ACCESS
    base = n_rsp;
    push_cmd(mk(1'b1, 32'h80, 32'h0BAD_0BAD, 2, 1'b1, 32'h0));
    push_cmd(mk(1'b0, 32'h84, 32'h0, 6, 1'b0, 32'h7777_7777));
    push_cmd(mk(1'b1, 32'h88, 32'h1, 0, 1'b0, 32'h0));
    guard = 0;
    while (!(exp_q.size() == 2 && psel && penable) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("reach_second_access", 128'(exp_q.size() == 2 && psel && penable), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {psel, penable, rsp_valid, busy, req_ready, paddr, pwdata}, '0);
    exp_q.delete();
    plan_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_idle", {busy, req_ready, psel}, 128'(3'b010));
    check("post_reset_rsp_count", 128'(n_rsp - base), 128'(1));

    // Randomised traffic with random back-pressure
    rsp_mode = 2;
    base = n_rsp;
    for (int i = 0; i < 60; i++) begin
      push_cmd(rand_plan(10));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    drain("drain_random", 3000);
    check("random_rsp_count", 128'(n_rsp - base), 128'(60));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
